// File: rtl/fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fp_mul_arbiter
//   Shares one 64-bit floating-point multiplier between two requesters.
//   It arbitrates round-robin, latches the winning operand pair, waits a fixed
//   number of cycles for the product, and presents the result on a tagged
//   valid/ready port. The arbiter never computes anything itself: the product
//   comes back from the external multiplier on mul_c.
//
//   Optional feature macro: FPMUL_ARB_STATS_EN
//     defined   -> grant0_cnt / grant1_cnt count grants per requester (wrapping)
//     undefined -> counter logic absent, both count outputs tied to 0
//
// Parameters
//   LAT    cycles the multiplier needs after its operands settle (>= 1)
//   CNT_W  width of the grant counters
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req0_valid/a/b, req0_ready   requester 0 operand pair, accept strobe
//   req1_valid/a/b, req1_ready   requester 1 operand pair, accept strobe
//   mul_a, mul_b, mul_en         registered operands and enable to multiplier
//   mul_c                        product from multiplier
//   rsp_valid, rsp_id, rsp_data  result, owner tag, handshaked by rsp_ready
//   grant0_cnt, grant1_cnt       grant counters (see macro above)
// -----------------------------------------------------------------------------
module fp_mul_arbiter #(
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [63:0]      req0_a,
  input  logic [63:0]      req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [63:0]      req1_a,
  input  logic [63:0]      req1_b,
  output logic             req1_ready,
  output logic [63:0]      mul_a,
  output logic [63:0]      mul_b,
  output logic             mul_en,
  input  logic [63:0]      mul_c,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [63:0]      rsp_data,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt
);

  localparam int WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic              last_grant_q;
  logic [WAIT_W-1:0] wait_q;
  logic              settle_q;
  logic [63:0]       mul_a_q;
  logic [63:0]       mul_b_q;
  logic              mul_en_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [63:0]       rsp_data_q;

  // Grant decision, only meaningful in IDLE. On a tie the requester that did
  // not win last time gets the slot; last_grant resets to 1 so req0 wins first.
  logic grant_any;
  logic grant_id;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any & ~grant_id;
  assign req1_ready = grant_any &  grant_id;

  // Sequencer. BUSY spends one cycle letting the freshly registered operands
  // reach the multiplier (settle_q), then LAT cycles counted by wait_q from
  // LAT-1 down to 0, after which mul_c is taken as the product. This puts
  // rsp_valid high after edge T+LAT+1 for an accept at edge T.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wait_q       <= '0;
      settle_q     <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_en_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            mul_a_q      <= grant_id ? req1_a : req0_a;
            mul_b_q      <= grant_id ? req1_b : req0_b;
            rsp_id_q     <= grant_id;
            last_grant_q <= grant_id;
            wait_q       <= WAIT_W'(LAT - 1);
            settle_q     <= 1'b0;
            mul_en_q     <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (!settle_q) begin
            settle_q <= 1'b1;
          end else if (wait_q == '0) begin
            rsp_data_q  <= mul_c;
            rsp_valid_q <= 1'b1;
            mul_en_q    <= 1'b0;
            state_q     <= DONE;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        DONE: begin
          // Result is frozen until the consumer takes it; no grants here.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_en    = mul_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef FPMUL_ARB_STATS_EN
  logic [CNT_W-1:0] grant0_cnt_q;
  logic [CNT_W-1:0] grant1_cnt_q;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant0_cnt_q <= '0;
      grant1_cnt_q <= '0;
    end else begin
      if (req0_ready) grant0_cnt_q <= grant0_cnt_q + CNT_W'(1);
      if (req1_ready) grant1_cnt_q <= grant1_cnt_q + CNT_W'(1);
    end
  end

  assign grant0_cnt = grant0_cnt_q;
  assign grant1_cnt = grant1_cnt_q;
`else
  assign grant0_cnt = '0;
  assign grant1_cnt = '0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_arbiter
//   Directed plus randomized bench for fp_mul_arbiter (LAT=1, CNT_W=16).
//   The expected grant order, owner tags, products and grant counts come from
//   a small reference model in this file: round-robin by "who won last", and
//   the product computed as a real-number multiply of the granted operands.
//   A stand-in multiplier drives mul_c one cycle after mul_en and drives a
//   junk pattern otherwise, so sampling mul_c at the wrong time shows up.
// -----------------------------------------------------------------------------
module tb_fp_mul_arbiter;

  localparam int LAT   = 1;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             req0_valid;
  logic [63:0]      req0_a;
  logic [63:0]      req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [63:0]      req1_a;
  logic [63:0]      req1_b;
  logic             req1_ready;
  logic [63:0]      mul_a;
  logic [63:0]      mul_b;
  logic             mul_en;
  logic [63:0]      mul_c;
  logic             rsp_valid;
  logic             rsp_id;
  logic [63:0]      rsp_data;
  logic             rsp_ready;
  logic [CNT_W-1:0] grant0_cnt;
  logic [CNT_W-1:0] grant1_cnt;

  fp_mul_arbiter #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_en     (mul_en),
    .mul_c      (mul_c),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .grant0_cnt (grant0_cnt),
    .grant1_cnt (grant1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in multiplier with one cycle of latency.
  always @(posedge clk) begin
    if (mul_en) mul_c <= $realtobits($bitstoreal(mul_a) * $bitstoreal(mul_b));
    else        mul_c <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic mdl_last;
  int   mdl_cnt0;
  int   mdl_cnt1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
`ifdef FPMUL_ARB_STATS_EN
    check({tag, ".cnt0"}, 64'(grant0_cnt), 64'(mdl_cnt0[CNT_W-1:0]));
    check({tag, ".cnt1"}, 64'(grant1_cnt), 64'(mdl_cnt1[CNT_W-1:0]));
`else
    check({tag, ".cnt0"}, 64'(grant0_cnt), 64'd0);
    check({tag, ".cnt1"}, 64'(grant1_cnt), 64'd0);
`endif
  endtask

  function automatic logic [63:0] rand_dbl();
    logic [63:0] v;
    v[63]    = 1'($urandom_range(0, 1));
    v[62:52] = 11'($urandom_range(900, 1100));
    v[51:32] = 20'($urandom);
    v[31:0]  = $urandom;
    return v;
  endfunction

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic void model_reset();
    mdl_last = 1'b1;
    mdl_cnt0 = 0;
    mdl_cnt1 = 0;
  endfunction

  // One complete transaction, entered and left just after a rising edge with
  // the DUT in IDLE. Returns the tag that was granted.
  task automatic run_op(input string tag, input logic v0, input logic v1,
                        input logic [63:0] a0, input logic [63:0] b0,
                        input logic [63:0] a1, input logic [63:0] b1,
                        input int stall, output logic got_id);
    logic        exp_id;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] ep;
    if (v0 && v1) exp_id = ~mdl_last;
    else          exp_id = v1;
    ea = exp_id ? a1 : a0;
    eb = exp_id ? b1 : b0;
    ep = ref_mul(ea, eb);

    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    check({tag, ".rdy0"}, 64'(req0_ready), 64'(!exp_id));
    check({tag, ".rdy1"}, 64'(req1_ready), 64'(exp_id));

    tick();  // accept edge T
    mdl_last = exp_id;
    if (exp_id) mdl_cnt1++; else mdl_cnt0++;
    check({tag, ".mul_a"}, mul_a, ea);
    check({tag, ".mul_b"}, mul_b, eb);
    check({tag, ".mul_en"}, 64'(mul_en), 64'd1);
    check({tag, ".busy_rdy"}, 64'({req0_ready, req1_ready}), 64'd0);

    repeat (LAT) begin
      tick();
      check({tag, ".early_valid"}, 64'(rsp_valid), 64'd0);
    end
    tick();  // edge T+LAT+1
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, ".rsp_id"}, 64'(rsp_id), 64'(exp_id));
    check({tag, ".rsp_data"}, rsp_data, ep);
    check({tag, ".mul_en_off"}, 64'(mul_en), 64'd0);

    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, ".hold_id"}, 64'(rsp_id), 64'(exp_id));
      check({tag, ".hold_data"}, rsp_data, ep);
      check({tag, ".done_rdy"}, 64'({req0_ready, req1_ready}), 64'd0);
    end

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, ".valid_drop"}, 64'(rsp_valid), 64'd0);
    check({tag, ".mul_a_held"}, mul_a, ea);
    check_counts(tag);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    got_id = exp_id;
    $display("op %s: id=%0d a=%h b=%h data=%h", tag, exp_id, ea, eb, rsp_data);
  endtask

  initial begin
    logic        id;
    logic        pat0;
    logic        pat1;
    logic [63:0] two   = 64'h4000_0000_0000_0000;
    logic [63:0] three = 64'h4008_0000_0000_0000;
    int          v;
    int          st;

    model_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b0;

    // Reset state
    #12;
    check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst.rsp_id", 64'(rsp_id), 64'd0);
    check("rst.rsp_data", rsp_data, 64'd0);
    check("rst.mul_a", mul_a, 64'd0);
    check("rst.mul_b", mul_b, 64'd0);
    check("rst.mul_en", 64'(mul_en), 64'd0);
    check("rst.rdy", 64'({req0_ready, req1_ready}), 64'd0);
    check_counts("rst");
    rst_n = 1'b1;
    tick();

    // Idle with nothing requested; stray rsp_ready is ignored
    rsp_ready = 1'b1;
    tick();
    tick();
    rsp_ready = 1'b0;
    check("idle.rsp_valid", 64'(rsp_valid), 64'd0);
    check("idle.mul_en", 64'(mul_en), 64'd0);
    check("idle.rdy", 64'({req0_ready, req1_ready}), 64'd0);
    $display("idle: no requests, rsp_valid=%0d", rsp_valid);

    // T2: tie out of reset -> req0 then req1
    run_op("t2a", 1'b1, 1'b1, two, three, three, three, 0, id);
    check("t2a.first", 64'(id), 64'd0);
    run_op("t2b", 1'b1, 1'b1, two, three, three, three, 0, id);
    check("t2b.second", 64'(id), 64'd1);

    // T1: req0 alone, 2.0 * 3.0
    run_op("t1", 1'b1, 1'b0, two, three, '0, '0, 0, id);
    check("t1.data_const", rsp_data, 64'h4018_0000_0000_0000);

    // T6: req1 alone, 0.0 * 3.0
    run_op("t6", 1'b0, 1'b1, '0, '0, 64'h0, three, 0, id);
    check("t6.data_const", rsp_data, 64'h0);
    check("t6.id", 64'(rsp_id), 64'd1);

    // T3: both held valid for six ops, alternating from req0
    for (int i = 0; i < 6; i++) begin
      run_op("t3", 1'b1, 1'b1, rand_dbl(), rand_dbl(), rand_dbl(), rand_dbl(), 0, id);
      check("t3.alt", 64'(id), 64'(i % 2));
    end

    // T4: consumer stalls five cycles in DONE
    run_op("t4", 1'b1, 1'b1, rand_dbl(), rand_dbl(), rand_dbl(), rand_dbl(), 5, id);

    // T5: reset while BUSY aborts the op silently
    req0_valid = 1'b1; req0_a = two;   req0_b = three;
    req1_valid = 1'b1; req1_a = three; req1_b = three;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t5.busy", 64'(mul_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5.rst_mul_en", 64'(mul_en), 64'd0);
    check("t5.rst_mul_a", mul_a, 64'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5.no_rsp", 64'(rsp_valid), 64'd0);
    end
    check_counts("t5");
    $display("t5: reset during BUSY, rsp_valid=%0d", rsp_valid);
    run_op("t5tie", 1'b1, 1'b1, rand_dbl(), rand_dbl(), rand_dbl(), rand_dbl(), 0, id);
    check("t5.tie_req0", 64'(id), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      v    = int'($urandom_range(1, 3));
      pat0 = v[0];
      pat1 = v[1];
      st   = int'($urandom_range(0, 3));
      run_op("rnd", pat0, pat1, rand_dbl(), rand_dbl(), rand_dbl(), rand_dbl(), st, id);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
